// File: rtl/trap_stall_sequencer.sv
//-----------------------------------------------------------------------------
// trap_stall_sequencer
//
// Purpose:
//   PC / front-end sequencer for the multi-stage RISC-V core. It owns the
//   fetch PC and the decoder enable. It sequences three kinds of redirect:
//     - conditional-branch redirects,
//     - maskable interrupt entry (MEPC/MCAUSE capture, jump to MTVEC),
//     - MRET return to MEPC.
//   Every redirect stalls decode for DRAIN_CYCLES cycles so the pipeline
//   can drain. The PC is a word index.
//
// Ports:
//   CLK             in   1        clock, all state updates on rising edge
//   RSTN            in   1        synchronous active-low reset
//   BRANCH_DETECT   in   1        conditional jump present in decode
//   JUMP_DEST       in   XLEN     branch target, valid the cycle after
//                                 BRANCH_DETECT
//   IRQ             in   NUM_IRQ  level-sensitive interrupt requests
//   IRQ_MASK        in   NUM_IRQ  per-line enable, 1 = enabled
//   MRET            in   1        mret decoded this cycle
//   MTVEC_WE        in   1        MTVEC write strobe
//   MTVEC_WDATA     in   XLEN     MTVEC write data
//   PC              out  XLEN     fetch address
//   DECODER_ENABLED out  1        decode stage enable
//   CPU_MODE        out  1        0 = user, 1 = machine
//   MEPC            out  XLEN     saved return PC
//   MCAUSE          out  XLEN     trap cause
//   MTVEC           out  XLEN     trap vector
//   IRQ_ACK         out  NUM_IRQ  one-hot, 1-cycle pulse on trap entry
//-----------------------------------------------------------------------------
module trap_stall_sequencer #(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned NUM_IRQ      = 4,
   parameter int unsigned DRAIN_CYCLES = 2,
   parameter int unsigned RESET_PC     = 0,
   parameter int unsigned MTVEC_RESET  = 36
) (
   input  logic               CLK,
   input  logic               RSTN,
   input  logic               BRANCH_DETECT,
   input  logic [XLEN-1:0]    JUMP_DEST,
   input  logic [NUM_IRQ-1:0] IRQ,
   input  logic [NUM_IRQ-1:0] IRQ_MASK,
   input  logic               MRET,
   input  logic               MTVEC_WE,
   input  logic [XLEN-1:0]    MTVEC_WDATA,
   output logic [XLEN-1:0]    PC,
   output logic               DECODER_ENABLED,
   output logic               CPU_MODE,
   output logic [XLEN-1:0]    MEPC,
   output logic [XLEN-1:0]    MCAUSE,
   output logic [XLEN-1:0]    MTVEC,
   output logic [NUM_IRQ-1:0] IRQ_ACK
);

   // Width of the drain down-counter and of an interrupt index.
   localparam int unsigned CW   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam int unsigned IDXW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

   localparam logic [CW-1:0]   CNT_INIT = CW'(DRAIN_CYCLES - 1);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
   localparam logic [XLEN-1:0] PC_ONE   = XLEN'(1);
   localparam logic [XLEN-1:0] PC_RST   = XLEN'(RESET_PC);
   localparam logic [XLEN-1:0] TVEC_RST = XLEN'(MTVEC_RESET);
   // Interrupt flag bit of MCAUSE.
   localparam logic [XLEN-1:0] CAUSE_IRQ = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [2:0] {
      ST_RUN        = 3'd0,
      ST_HANDLER    = 3'd1,
      ST_BR_DRAIN   = 3'd2,
      ST_TRAP_DRAIN = 3'd3,
      ST_RET_DRAIN  = 3'd4
   } state_t;

   // Index of the lowest set bit; lower index means higher priority.
   function automatic logic [IDXW-1:0] f_lowest_idx(input logic [NUM_IRQ-1:0] v);
      logic [IDXW-1:0] idx;
      idx = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (v[i]) begin
            idx = IDXW'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   // Registered state
   state_t               r_state;
   state_t               r_ret_state;
   logic [CW-1:0]        r_cnt;
   logic [XLEN-1:0]      r_pc;
   logic                 r_dec_en;
   logic                 r_mode;
   logic [XLEN-1:0]      r_mepc;
   logic [XLEN-1:0]      r_mcause;
   logic [XLEN-1:0]      r_mtvec;
   logic [NUM_IRQ-1:0]   r_irq_ack;

   // Next-state values
   state_t               w_state_nxt;
   state_t               w_ret_state_nxt;
   logic [CW-1:0]        w_cnt_nxt;
   logic [XLEN-1:0]      w_pc_nxt;
   logic                 w_dec_en_nxt;
   logic                 w_mode_nxt;
   logic [XLEN-1:0]      w_mepc_nxt;
   logic [XLEN-1:0]      w_mcause_nxt;
   logic [XLEN-1:0]      w_mtvec_nxt;
   logic [NUM_IRQ-1:0]   w_irq_ack_nxt;

   // Interrupt selection
   logic [NUM_IRQ-1:0]   w_pending;
   logic                 w_irq_any;
   logic [IDXW-1:0]      w_irq_idx;
   logic [NUM_IRQ-1:0]   w_irq_onehot;
   logic [XLEN-1:0]      w_irq_cause;
   logic [XLEN-1:0]      w_pc_inc;

   assign w_pending    = IRQ & IRQ_MASK;
   assign w_irq_any    = |w_pending;
   assign w_irq_idx    = f_lowest_idx(w_pending);
   assign w_irq_onehot = NUM_IRQ'(1'b1) << w_irq_idx;
   assign w_irq_cause  = CAUSE_IRQ | XLEN'(w_irq_idx);
   assign w_pc_inc     = r_pc + PC_ONE;

   // Next-state and datapath decision for the sequencer FSM.
   always_comb begin
      w_state_nxt     = r_state;
      w_ret_state_nxt = r_ret_state;
      w_cnt_nxt       = r_cnt;
      w_pc_nxt        = r_pc;
      w_dec_en_nxt    = r_dec_en;
      w_mode_nxt      = r_mode;
      w_mepc_nxt      = r_mepc;
      w_mcause_nxt    = r_mcause;
      w_irq_ack_nxt   = '0;

      // MTVEC writes are accepted in every state; the trap exit below reads
      // r_mtvec, so an exit on the same edge as a write uses the old vector.
      if (MTVEC_WE) begin
         w_mtvec_nxt = MTVEC_WDATA;
      end else begin
         w_mtvec_nxt = r_mtvec;
      end

      case (r_state)
         ST_RUN: begin
            if (BRANCH_DETECT) begin
               w_dec_en_nxt    = 1'b0;
               w_cnt_nxt       = CNT_INIT;
               w_ret_state_nxt = ST_RUN;
               w_state_nxt     = ST_BR_DRAIN;
            end else if (w_irq_any) begin
               w_mepc_nxt    = r_pc;
               w_mcause_nxt  = w_irq_cause;
               w_mode_nxt    = 1'b1;
               w_irq_ack_nxt = w_irq_onehot;
               w_dec_en_nxt  = 1'b0;
               w_cnt_nxt     = CNT_INIT;
               w_state_nxt   = ST_TRAP_DRAIN;
            end else begin
               // MRET in user mode is ignored and fetch just advances.
               w_pc_nxt = w_pc_inc;
            end
         end

         ST_HANDLER: begin
            // Interrupts are not taken here; they stay pending until RUN.
            if (BRANCH_DETECT) begin
               w_dec_en_nxt    = 1'b0;
               w_cnt_nxt       = CNT_INIT;
               w_ret_state_nxt = ST_HANDLER;
               w_state_nxt     = ST_BR_DRAIN;
            end else if (MRET) begin
               w_dec_en_nxt = 1'b0;
               w_cnt_nxt    = CNT_INIT;
               w_state_nxt  = ST_RET_DRAIN;
            end else begin
               w_pc_nxt = w_pc_inc;
            end
         end

         ST_BR_DRAIN: begin
            // JUMP_DEST is valid exactly one cycle after BRANCH_DETECT,
            // which is the first drain cycle.
            if (r_cnt == CNT_INIT) begin
               w_pc_nxt = JUMP_DEST;
            end else begin
               w_pc_nxt = r_pc;
            end
            if (r_cnt == '0) begin
               w_dec_en_nxt = 1'b1;
               w_pc_nxt     = w_pc_inc;
               w_state_nxt  = r_ret_state;
            end else begin
               w_cnt_nxt = r_cnt - CNT_ONE;
            end
         end

         ST_TRAP_DRAIN: begin
            if (r_cnt == '0) begin
               w_pc_nxt     = r_mtvec;
               w_dec_en_nxt = 1'b1;
               w_state_nxt  = ST_HANDLER;
            end else begin
               w_cnt_nxt = r_cnt - CNT_ONE;
            end
         end

         ST_RET_DRAIN: begin
            if (r_cnt == '0) begin
               w_pc_nxt     = r_mepc;
               w_mode_nxt   = 1'b0;
               w_dec_en_nxt = 1'b1;
               w_state_nxt  = ST_RUN;
            end else begin
               w_cnt_nxt = r_cnt - CNT_ONE;
            end
         end

         default: begin
            // Unreachable encoding: fall back to a clean running state.
            w_state_nxt  = ST_RUN;
            w_cnt_nxt    = '0;
            w_dec_en_nxt = 1'b1;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         r_state     <= ST_RUN;
         r_ret_state <= ST_RUN;
         r_cnt       <= '0;
         r_pc        <= PC_RST;
         r_dec_en    <= 1'b1;
         r_mode      <= 1'b0;
         r_mepc      <= '0;
         r_mcause    <= '0;
         r_mtvec     <= TVEC_RST;
         r_irq_ack   <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_ret_state <= w_ret_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_pc        <= w_pc_nxt;
         r_dec_en    <= w_dec_en_nxt;
         r_mode      <= w_mode_nxt;
         r_mepc      <= w_mepc_nxt;
         r_mcause    <= w_mcause_nxt;
         r_mtvec     <= w_mtvec_nxt;
         r_irq_ack   <= w_irq_ack_nxt;
      end
   end

   assign PC              = r_pc;
   assign DECODER_ENABLED = r_dec_en;
   assign CPU_MODE        = r_mode;
   assign MEPC            = r_mepc;
   assign MCAUSE          = r_mcause;
   assign MTVEC           = r_mtvec;
   assign IRQ_ACK         = r_irq_ack;

endmodule
